seg_display_scan: RTL
=====================

Name: seg_display_scan

Overview:
- Downstream consumer of the stopwatch digit counters; takes the four BCD digit values (min1, min0, sec1, sec0) and drives a 4-digit common-anode seven-segment display by time-multiplexing.
- Provides digit refresh scanning, anti-ghosting blank slots, and blinking of the minute or second field during adjust mode, using a slow blink clock supplied by the clock divider.

Parameters:
- REFRESH_DIV, 100000, system clocks per digit slot; legal range is at least 2. The default gives 1 kHz slot rate and 250 Hz per digit at 100 MHz.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- min1  input  32  tens-of-minutes digit value.
- min0  input  32  minutes digit value.
- sec1  input  32  tens-of-seconds digit value.
- sec0  input  32  seconds digit value.
- blink_clock  input  1  slow blink source, e.g. 2 Hz; asynchronous to the scan and synchronised internally.
- adj_min  input  1  blink minute digits.
- adj_sec  input  1  blink second digits.
- seg  output  8  active-low cathodes, ordered {dp,g,f,e,d,c,b,a}.
- an  output  4  active-low anodes; an[0] is the rightmost digit (sec0) and an[3] is min1.

Behaviour:
- Reset asserted (reset=0), applied asynchronously:
  - an=4'b1111, seg=8'hFF.
  - Slot counter=0, digit index=0, guard flag=0, synchroniser flops=0.
- Slot counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - Reaching REFRESH_DIV-1 is a "tick".
- Digit index: 2-bit, advances on each tick, 0→1→2→3→0. Mapping is 0=sec0, 1=sec1, 2=min0, 3=min1.
- Guard: on the cycle following each tick, an=4'b1111 and seg=8'hFF for exactly one clock. This is the anti-ghost slot.
- Outside the guard cycle:
  - an drives the one-cold pattern for the current index (index 0 → 4'b1110, 3 → 4'b0111).
  - seg shows the decoded selected digit.
- Outputs are registered; combinational paths from the inputs to the outputs are not allowed. A change on a digit input appears on seg one clock later, if that digit is currently selected.
- First cycle after reset release: guard=0, index=0, so an=4'b1110 with sec0 decoded on the next edge.
- Decode:
  - Compare the full 32-bit value.
  - seg[6:0] for 0–9: 40,79,24,30,19,12,02,78,00,10 (hex).
  - Any value ≥10 shows a dash (seg[6:0]=7'h3F).
- Blink:
  - blink_clock passes through a 2-flop synchroniser; its output is blink_s.
  - When blink_s=1 and adj_min=1, digits with index 2 or 3 are blanked (seg=8'hFF; an still driven).
  - When blink_s=1 and adj_sec=1, digits with index 0 or 1 are blanked.
  - When both adjust inputs are set, all four digits blink together.
  - When blink_s=0, digits display normally regardless of the adjust inputs.
- seg[7] (dp) is 1 (off) except as described under Optional Feature.
- Reset asserted mid-scan: outputs blank immediately. After release, scanning restarts at index 0 with the slot counter at 0.

Optional Feature:
- Macro: SEG_COLON_DP_EN.
- Defined: the dp cathode of digit index 2 (min0) is lit (seg[7]=0) whenever that digit is displayed and not blanked by blink or guard. This gives the MM.SS separator.
- Undefined: seg[7] is constantly 1 and no dp logic is synthesised.

Test Plan:
- Reset and first scan: REFRESH_DIV=4, inputs min1=1, min0=2, sec1=3, sec0=4.
  - During reset: an=1111, seg=FF.
  - After release, in order: an=1110/seg=99h(dp off) for sec0=4; guard; an=1101/seg=B0h; guard; an=1011/seg=A4h (24h when SEG_COLON_DP_EN is defined); guard; an=0111/seg=F9h; then wraps back to an=1110.
- Guard timing: count clocks between ticks. Each slot is REFRESH_DIV clocks, of which exactly one clock has an=1111.
- Out-of-range value: sec1=32'd10, then 32'h8000_0003. Digit index 1 shows seg[6:0]=3Fh in both cases; the upper bits are not truncated.
- Blink: adj_min=1, blink_clock held at 1 for more than 3 clocks.
  - Indices 2 and 3 show seg=FF while their an bits are still low; indices 0 and 1 display normally.
  - With blink_clock=0, all four digits display.
  - With adj_min=adj_sec=1 and blink high, all four digits show seg=FF.
- Mid-scan reset: assert reset while index=2. an=1111 and seg=FF the same instant, without waiting for a clock edge. After release, the first displayed digit is index 0.
- Live update: change sec0 from 4 to 7 while index 0 is active. seg becomes F8h on the next rising edge.

Source files
------------

// File: rtl/seg_display_scan.sv
// Four-digit common-anode seven-segment scanner with one-clock anti-ghost guard slots and adjust-mode blinking.
// Optional MM.SS separator (dp on the min0 digit) is enabled with `define SEG_COLON_DP_EN.
module seg_display_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] min1,
  input  logic [31:0] min0,
  input  logic [31:0] sec1,
  input  logic [31:0] sec0,
  input  logic        blink_clock,
  input  logic        adj_min,
  input  logic        adj_sec,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          guard_q, guard_d;
  logic          blink_meta_q, blink_s_q;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    an_q, an_d;
  logic          tick;
  logic          blank;
  logic [31:0]   digit;

  // Full-width compare so out-of-range values are never aliased onto a valid digit.
  function automatic logic [6:0] decode(input logic [31:0] v);
    case (v)
      32'd0:   decode = 7'h40;
      32'd1:   decode = 7'h79;
      32'd2:   decode = 7'h24;
      32'd3:   decode = 7'h30;
      32'd4:   decode = 7'h19;
      32'd5:   decode = 7'h12;
      32'd6:   decode = 7'h02;
      32'd7:   decode = 7'h78;
      32'd8:   decode = 7'h00;
      32'd9:   decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  always_comb begin
    tick    = (cnt_q == LAST);
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    guard_d = tick;

    case (idx_q)
      2'd0:    digit = sec0;
      2'd1:    digit = sec1;
      2'd2:    digit = min0;
      default: digit = min1;
    endcase

    // Blink blanks cathodes only; the anode stays driven so the slot timing is unchanged.
    blank = guard_q | (blink_s_q & ((adj_min & idx_q[1]) | (adj_sec & ~idx_q[1])));

    an_d  = guard_q ? 4'hF : ~(4'b0001 << idx_q);
    seg_d = 8'hFF;
    if (!blank) begin
      seg_d[6:0] = decode(digit);
`ifdef SEG_COLON_DP_EN
      seg_d[7] = (idx_q != 2'd2);
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      guard_q      <= 1'b0;
      blink_meta_q <= 1'b0;
      blink_s_q    <= 1'b0;
      seg_q        <= 8'hFF;
      an_q         <= 4'hF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      guard_q      <= guard_d;
      blink_meta_q <= blink_clock;
      blink_s_q    <= blink_meta_q;
      seg_q        <= seg_d;
      an_q         <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule
